// File: rtl/ulpi_phy_responder.sv
// rtl/ulpi_phy_responder.sv - PHY-side ULPI bus responder for link loopback and bench use
module ulpi_phy_responder #(
  parameter int         MAX_TX_BYTES = 512,
  parameter logic [1:0] LINESTATE    = 2'b01
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] ulpi_data_in,
  input  logic       ulpi_stp,
  output logic       ulpi_dir,
  output logic       ulpi_nxt,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_oe,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_last,
  output logic       rx_ready,
  output logic [7:0] tx_cmd,
  output logic       tx_byte_valid,
  output logic [7:0] tx_byte,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int CW = $clog2(MAX_TX_BYTES + 1);

  // RX CMD bytes: RxActive lives in bit 4, line state in bits [1:0]
  localparam logic [7:0] RXCMD_ACTIVE = {2'b00, 2'b01, 2'b00, LINESTATE};
  localparam logic [7:0] RXCMD_END    = {6'b000000, LINESTATE};

  typedef enum logic [2:0] {
    IDLE,
    TX_CMD,
    TX_DATA,
    TX_DRAIN,
    TURN_UP,
    RX_DATA,
    RX_END,
    TURN_DN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic          last_byte;

  // The byte taken in this cycle is the one that fills the packet budget
  assign last_byte = (count == CW'(MAX_TX_BYTES - 1));

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and bus outputs decoded from the current state
  always_comb begin
    state_nxt     = state;
    ulpi_dir      = 1'b0;
    ulpi_nxt      = 1'b0;
    ulpi_oe       = 1'b0;
    ulpi_data_out = 8'h00;
    rx_ready      = 1'b0;
    unique case (state)
      IDLE: begin
        // A link TX CMD wins over a pending RX packet
        if (ulpi_data_in[7:6] == 2'b01) begin
          state_nxt = TX_CMD;
        end else if (rx_valid) begin
          state_nxt = TURN_UP;
        end
      end
      TX_CMD: begin
        ulpi_nxt  = 1'b1;
        state_nxt = TX_DATA;
      end
      TX_DATA: begin
        ulpi_nxt = 1'b1;
        if (ulpi_stp) begin
          state_nxt = IDLE;
        end else if (last_byte) begin
          state_nxt = TX_DRAIN;
        end
      end
      TX_DRAIN: begin
        if (ulpi_stp) begin
          state_nxt = IDLE;
        end
      end
      TURN_UP: begin
        ulpi_dir  = 1'b1;
        ulpi_nxt  = 1'b1;
        state_nxt = RX_DATA;
      end
      RX_DATA: begin
        ulpi_dir = 1'b1;
        ulpi_oe  = 1'b1;
        if (rx_valid) begin
          ulpi_nxt      = 1'b1;
          ulpi_data_out = rx_data;
          rx_ready      = 1'b1;
          if (rx_last) begin
            state_nxt = RX_END;
          end
        end else begin
          ulpi_data_out = RXCMD_ACTIVE;
        end
      end
      RX_END: begin
        ulpi_dir      = 1'b1;
        ulpi_oe       = 1'b1;
        ulpi_data_out = RXCMD_END;
        state_nxt     = TURN_DN;
      end
      TURN_DN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // TX capture path: command byte, data bytes, byte budget and end-of-packet flags
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_cmd        <= 8'h00;
      tx_byte_valid <= 1'b0;
      tx_byte       <= 8'h00;
      tx_done       <= 1'b0;
      tx_err        <= 1'b0;
      count         <= '0;
    end else begin
      tx_byte_valid <= 1'b0;
      tx_done       <= 1'b0;
      unique case (state)
        TX_CMD: begin
          tx_cmd <= ulpi_data_in;
          count  <= '0;
          tx_err <= 1'b0;
        end
        TX_DATA: begin
          if (ulpi_stp) begin
            tx_done <= 1'b1;
          end else begin
            tx_byte_valid <= 1'b1;
            tx_byte       <= ulpi_data_in;
            count         <= count + CW'(1);
            if (last_byte) begin
              tx_err <= 1'b1;
            end
          end
        end
        TX_DRAIN: begin
          if (ulpi_stp) begin
            tx_done <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// tb/tb_ulpi_phy_responder.sv - self-checking bench for ulpi_phy_responder
module tb_ulpi_phy_responder;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] ulpi_data_in = 8'h00;
  logic       ulpi_stp = 1'b0;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic [7:0] ulpi_data_out;
  logic       ulpi_oe;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_last = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_cmd;
  logic       tx_byte_valid;
  logic [7:0] tx_byte;
  logic       tx_done;
  logic       tx_err;

  int errors = 0;
  int checks = 0;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic        rxv;
    logic [7:0]  rxd;
    logic        rxl;
    logic [7:0]  din;
    logic        stp;
    logic [30:0] exp;
  } vec_t;

  vec_t tbl[$];

  ulpi_phy_responder dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .ulpi_data_in  (ulpi_data_in),
    .ulpi_stp      (ulpi_stp),
    .ulpi_dir      (ulpi_dir),
    .ulpi_nxt      (ulpi_nxt),
    .ulpi_data_out (ulpi_data_out),
    .ulpi_oe       (ulpi_oe),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_last       (rx_last),
    .rx_ready      (rx_ready),
    .tx_cmd        (tx_cmd),
    .tx_byte_valid (tx_byte_valid),
    .tx_byte       (tx_byte),
    .tx_done       (tx_done),
    .tx_err        (tx_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [30:0] outv();
    return {ulpi_dir, ulpi_nxt, ulpi_oe, ulpi_data_out, rx_ready, tx_byte_valid,
            (tx_byte_valid ? tx_byte : 8'h00), tx_done, tx_err, tx_cmd};
  endfunction

  function automatic vec_t mk(logic rxv, logic [7:0] rxd, logic rxl, logic [7:0] din, logic stp,
                              logic dir, logic nxt, logic oe, logic [7:0] dout, logic rdy,
                              logic tbv, logic [7:0] tb, logic done, logic err, logic [7:0] cmd);
    vec_t v;
    v.rxv = rxv; v.rxd = rxd; v.rxl = rxl; v.din = din; v.stp = stp;
    v.exp = {dir, nxt, oe, dout, rdy, tbv, tb, done, err, cmd};
    return v;
  endfunction

  function automatic int qdiff(bq_t a, bq_t b);
    int d = 0;
    if (a.size() != b.size()) return 1000 + a.size();
    foreach (a[i]) if (a[i] !== b[i]) d++;
    return d;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One RX packet of len bytes with random mid-packet gaps
  task automatic rx_packet(int len);
    bq_t pkt, got;
    int idx = 0, gaps = 0, dircyc = 0, ends = 0, n11 = 0, other = 0, cyc = 0;
    bit seen_dir = 0, closed = 0;
    logic drop;
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    ulpi_data_in = 8'h00;
    ulpi_stp = 1'b0;
    while (cyc < 200 && !closed) begin
      drop = (idx > 0) && (idx < len) && ($urandom_range(0, 3) == 0);
      rx_valid = (idx < len) && !drop;
      rx_data  = rx_valid ? pkt[idx] : 8'h00;
      rx_last  = rx_valid && (idx == len - 1);
      if (drop) gaps++;
      @(negedge clk);
      if (rx_ready) idx++;
      if (ulpi_dir) begin
        seen_dir = 1;
        dircyc++;
        if (ulpi_oe) begin
          if (ulpi_nxt) got.push_back(ulpi_data_out);
          else if (ulpi_data_out == 8'h01) ends++;
          else if (ulpi_data_out == 8'h11) n11++;
          else other++;
        end
      end else if (seen_dir) begin
        closed = 1;
      end
      next_cycle();
      cyc++;
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    check("rx_rand_timeout", closed, 1);
    check("rx_rand_data", qdiff(got, pkt), 0);
    check("rx_rand_gap_cmds", n11, gaps);
    check("rx_rand_end_cmd", {ends, other}, {32'd1, 32'd0});
    check("rx_rand_dir_cycles", dircyc, len + gaps + 2);
  endtask

  // One TX packet: command byte, len data bytes, then stp
  task automatic tx_packet(int len);
    bq_t pkt, got;
    logic [7:0] cmd;
    int ndone = 0, nxt_bad = 0, dir_bad = 0;
    int total = len + 6;
    logic exp_nxt;
    cmd = {2'b01, 6'($urandom)};
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    rx_valid = 1'b0;
    for (int c = 0; c < total; c++) begin
      ulpi_stp = 1'b0;
      if (c < 2) ulpi_data_in = cmd;
      else if (c < 2 + len) ulpi_data_in = pkt[c - 2];
      else if (c == 2 + len) begin ulpi_data_in = 8'($urandom); ulpi_stp = 1'b1; end
      else ulpi_data_in = 8'h00;
      exp_nxt = (c >= 1) && (c <= 2 + len);
      @(negedge clk);
      if (ulpi_nxt !== exp_nxt) nxt_bad++;
      if (ulpi_dir !== 1'b0) dir_bad++;
      if (tx_byte_valid) got.push_back(tx_byte);
      if (tx_done) ndone++;
      next_cycle();
    end
    ulpi_stp = 1'b0;
    check("tx_rand_bytes", qdiff(got, pkt), 0);
    check("tx_rand_done", ndone, 1);
    check("tx_rand_nxt", {nxt_bad, dir_bad}, 64'd0);
    check("tx_rand_cmd_err", {tx_cmd, tx_err}, {cmd, 1'b0});
  endtask

  initial begin
    int nv, bad_val, bad_nxt, ndone, wait_cyc;
    bit found;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", outv(), 31'd0);
    n_rst = 1'b1;
    next_cycle();

    // Directed cycle table: RX continuous, RX with gaps, TX 0x41, TX vs RX priority
    tbl.push_back(mk(1,8'hA5,0,8'h00,0, 0,0,0,8'h00,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(1,8'hA5,0,8'h00,0, 1,1,0,8'h00,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(1,8'hA5,0,8'h00,0, 1,1,1,8'hA5,1, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(1,8'h3C,0,8'h00,0, 1,1,1,8'h3C,1, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(1,8'hFF,1,8'h00,0, 1,1,1,8'hFF,1, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 1,0,1,8'h01,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(1,8'h5A,0,8'h00,0, 0,0,0,8'h00,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(1,8'h5A,0,8'h00,0, 1,1,0,8'h00,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(1,8'h5A,0,8'h00,0, 1,1,1,8'h5A,1, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 1,0,1,8'h11,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 1,0,1,8'h11,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(1,8'h6B,1,8'h00,0, 1,1,1,8'h6B,1, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 1,0,1,8'h01,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(0,8'h00,0,8'h41,0, 0,0,0,8'h00,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(0,8'h00,0,8'h41,0, 0,1,0,8'h00,0, 0,8'h00,0,0,8'h00));
    tbl.push_back(mk(0,8'h00,0,8'h01,0, 0,1,0,8'h00,0, 0,8'h00,0,0,8'h41));
    tbl.push_back(mk(0,8'h00,0,8'h02,0, 0,1,0,8'h00,0, 1,8'h01,0,0,8'h41));
    tbl.push_back(mk(0,8'h00,0,8'h03,0, 0,1,0,8'h00,0, 1,8'h02,0,0,8'h41));
    tbl.push_back(mk(0,8'h00,0,8'h04,0, 0,1,0,8'h00,0, 1,8'h03,0,0,8'h41));
    tbl.push_back(mk(0,8'h00,0,8'h00,1, 0,1,0,8'h00,0, 1,8'h04,0,0,8'h41));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0, 0,8'h00,1,0,8'h41));
    tbl.push_back(mk(1,8'h77,1,8'h40,0, 0,0,0,8'h00,0, 0,8'h00,0,0,8'h41));
    tbl.push_back(mk(1,8'h77,1,8'h40,0, 0,1,0,8'h00,0, 0,8'h00,0,0,8'h41));
    tbl.push_back(mk(1,8'h77,1,8'h00,1, 0,1,0,8'h00,0, 0,8'h00,0,0,8'h40));
    tbl.push_back(mk(1,8'h77,1,8'h00,0, 0,0,0,8'h00,0, 0,8'h00,1,0,8'h40));
    tbl.push_back(mk(1,8'h77,1,8'h00,0, 1,1,0,8'h00,0, 0,8'h00,0,0,8'h40));
    tbl.push_back(mk(1,8'h77,1,8'h00,0, 1,1,1,8'h77,1, 0,8'h00,0,0,8'h40));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 1,0,1,8'h01,0, 0,8'h00,0,0,8'h40));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0, 0,8'h00,0,0,8'h40));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0, 0,8'h00,0,0,8'h40));

    foreach (tbl[i]) begin
      rx_valid = tbl[i].rxv;
      rx_data = tbl[i].rxd;
      rx_last = tbl[i].rxl;
      ulpi_data_in = tbl[i].din;
      ulpi_stp = tbl[i].stp;
      @(negedge clk);
      check($sformatf("vec%0d", i), outv(), tbl[i].exp);
      next_cycle();
    end
    rx_valid = 1'b0; rx_data = 8'h00; rx_last = 1'b0; ulpi_data_in = 8'h00; ulpi_stp = 1'b0;

    // Overflow: 513 bytes against a 512-byte budget
    nv = 0; bad_val = 0; bad_nxt = 0; ndone = 0;
    ulpi_data_in = 8'h41;
    next_cycle();
    @(negedge clk);
    check("ovf_cmd_nxt", ulpi_nxt, 1);
    next_cycle();
    for (int k = 0; k <= 512; k++) begin
      ulpi_data_in = k[7:0];
      @(negedge clk);
      if (ulpi_nxt !== (k < 512)) bad_nxt++;
      if (tx_byte_valid) begin
        if (tx_byte !== nv[7:0]) bad_val++;
        nv++;
      end
      next_cycle();
    end
    ulpi_data_in = 8'h00;
    ulpi_stp = 1'b1;
    @(negedge clk);
    check("ovf_drain_nxt_err", {ulpi_nxt, tx_err}, 2'b01);
    if (tx_byte_valid) nv++;
    next_cycle();
    ulpi_stp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (tx_done) ndone++;
      if (tx_byte_valid) nv++;
      next_cycle();
    end
    check("ovf_byte_count", nv, 512);
    check("ovf_byte_values", bad_val, 0);
    check("ovf_nxt_pattern", bad_nxt, 0);
    check("ovf_done", ndone, 1);
    check("ovf_err_sticky", tx_err, 1);
    // A fresh TX CMD clears the overflow flag
    ulpi_data_in = 8'h42;
    next_cycle();
    next_cycle();
    ulpi_data_in = 8'h00;
    ulpi_stp = 1'b1;
    next_cycle();
    ulpi_stp = 1'b0;
    next_cycle();
    @(negedge clk);
    check("ovf_err_cleared", {tx_err, tx_cmd}, {1'b0, 8'h42});
    next_cycle();

    // Async reset in the middle of RX_DATA
    rx_valid = 1'b1; rx_data = 8'h99; rx_last = 1'b0;
    found = 0;
    wait_cyc = 0;
    while (!found && wait_cyc < 10) begin
      @(negedge clk);
      if (ulpi_dir && ulpi_oe) found = 1;
      else begin next_cycle(); wait_cyc++; end
    end
    check("rst_reach_rxdata", found, 1);
    n_rst = 1'b0;
    next_cycle();
    check("rst_mid_rx", {ulpi_dir, ulpi_nxt, ulpi_oe, rx_ready}, 4'd0);
    rx_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    next_cycle();
    @(negedge clk);
    check("rst_release_idle", outv(), 31'd0);
    next_cycle();
    rx_valid = 1'b1; rx_data = 8'h12; rx_last = 1'b1;
    @(negedge clk);
    check("rst_then_idle_dir", ulpi_dir, 0);
    next_cycle();
    @(negedge clk);
    check("rst_then_turn_up", {ulpi_dir, ulpi_nxt, ulpi_oe}, 3'b110);
    next_cycle();
    @(negedge clk);
    check("rst_then_byte", {ulpi_data_out, rx_ready}, {8'h12, 1'b1});
    next_cycle();
    rx_valid = 1'b0; rx_last = 1'b0; rx_data = 8'h00;
    repeat (3) next_cycle();

    // Randomized packet mix against the transaction-level model
    for (int p = 0; p < 30; p++) begin
      if ($urandom_range(0, 1) == 0) rx_packet($urandom_range(1, 8));
      else tx_packet($urandom_range(0, 20));
      if ($urandom_range(0, 1) == 1) next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
